apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_slave_ifc.sv | 24 ++
 rtl/apb_slave_mem_array.sv | 33 +++
 rtl/apb_slave_mem.sv | 114 +++++++++++
 tb/tb_apb_slave_mem.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, defaults and helpers for the APB slave memory
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_STATES = 2;

  // Width of a word index into a storage array of the given depth.
  function automatic int apb_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_ifc.sv
// rtl/apb_slave_ifc.sv - APB bus bundle with the slave-side modport
interface apb_slave_ifc #(
  parameter int ADDR_WIDTH = apb_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DEF_DATA_WIDTH
) (
  input logic PCLK,
  input logic PRESETn
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport APB_SLV (
    input  PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_mem_array.sv
// rtl/apb_slave_mem_array.sv - word storage: one write port, async read, sync clear
module apb_slave_mem_array
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IDX_W      = apb_idx_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Clear wipes every word and wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave with wait states in front of a word memory
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = apb_idx_w(DEPTH);

  apb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  oor_q, oor_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  setup_oor;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Address check is done on the full bus address so aliases above DEPTH are rejected.
  assign setup_oor = (32'(PADDR) >= 32'(DEPTH));

  apb_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (PCLK),
    .clr   (~PRESETn),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (PWDATA),
    .raddr (IDX_W'(PADDR)),
    .rdata (mem_rdata)
  );

  // Next-state: latch the setup, count down wait states, complete or abort.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    oor_d    = oor_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ACCESS;
          addr_d   = IDX_W'(PADDR);
          write_d  = PWRITE;
          oor_d    = setup_oor;
          cnt_d    = 4'(WAIT_STATES);
          prdata_d = (!PWRITE && !setup_oor) ? mem_rdata : '0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d  = IDLE;
          cnt_d    = 4'd0;
          prdata_d = '0;
        end else if (PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d  = IDLE;
            prdata_d = '0;
            mem_we   = write_q && !oor_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      oor_q    <= 1'b0;
      cnt_q    <= 4'd0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      oor_q    <= oor_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign PSLVERR = PREADY && oor_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed plus random checks of apb_slave_mem against a word-array model
module tb_apb_slave_mem;

  logic        clk = 1'b0;
  logic        presetn;
  logic        psel0, psel1;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;

  logic [31:0] prdata1;
  logic        pready1, pslverr1;

  int          cur;
  logic [31:0] prdata_c;
  logic        pready_c, pslverr_c;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [2][64];

  always #5 clk = ~clk;

  apb_slave_ifc #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ifc0 (.PCLK(clk), .PRESETn(presetn));

  assign ifc0.PSEL    = psel0;
  assign ifc0.PENABLE = penable;
  assign ifc0.PWRITE  = pwrite;
  assign ifc0.PADDR   = paddr;
  assign ifc0.PWDATA  = pwdata;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(2)) dut0 (
    .PCLK    (ifc0.PCLK),
    .PRESETn (ifc0.PRESETn),
    .PSEL    (ifc0.PSEL),
    .PENABLE (ifc0.PENABLE),
    .PWRITE  (ifc0.PWRITE),
    .PADDR   (ifc0.PADDR),
    .PWDATA  (ifc0.PWDATA),
    .PRDATA  (ifc0.PRDATA),
    .PREADY  (ifc0.PREADY),
    .PSLVERR (ifc0.PSLVERR)
  );

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) dut1 (
    .PCLK    (clk),
    .PRESETn (presetn),
    .PSEL    (psel1),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata1),
    .PREADY  (pready1),
    .PSLVERR (pslverr1)
  );

  assign prdata_c  = (cur == 1) ? prdata1  : ifc0.PRDATA;
  assign pready_c  = (cur == 1) ? pready1  : ifc0.PREADY;
  assign pslverr_c = (cur == 1) ? pslverr1 : ifc0.PSLVERR;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete transfer on slave d; expected latency is ws+1 ACCESS cycles.
  task automatic xfer(input int d, input bit wr, input int addr, input logic [31:0] data, input int ws);
    int          cyc;
    bit          done;
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    cur     = d;
    psel0   = (d == 0);
    psel1   = (d == 1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr[7:0];
    pwdata  = data;
    @(negedge clk);
    chk("setup_pready", {31'd0, pready_c}, 32'd0);
    chk("setup_prdata", prdata_c, 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = ~paddr;
    pwrite  = ~wr;
    cyc  = 1;
    done = 1'b0;
    rd   = '0;
    err  = 1'b0;
    while (!done && cyc <= 20) begin
      @(negedge clk);
      if (pready_c) begin
        done = 1'b1;
        rd   = prdata_c;
        err  = pslverr_c;
      end else begin
        chk("wait_pslverr", {31'd0, pslverr_c}, 32'd0);
        cyc++;
        @(posedge clk); #1;
      end
    end
    chk("xfer_done", {31'd0, done}, 32'd1);
    chk("xfer_latency", cyc, ws + 1);
    chk("xfer_pslverr", {31'd0, err}, (addr >= 64) ? 32'd1 : 32'd0);
    exp_rd = (wr || addr >= 64) ? 32'd0 : ref_mem[d][addr];
    chk(wr ? "write_prdata" : "read_prdata", rd, exp_rd);
    if (wr && addr < 64) ref_mem[d][addr] = data;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    chk("idle_pready", {31'd0, pready_c}, 32'd0);
    chk("idle_prdata", prdata_c, 32'd0);
  endtask

  // Transfer on slave 0 whose PSEL drops in the second ACCESS cycle.
  task automatic abort_xfer(input bit wr, input int addr, input logic [31:0] data);
    @(posedge clk); #1;
    cur     = 0;
    psel0   = 1'b1;
    psel1   = 1'b0;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr[7:0];
    pwdata  = data;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_c1_pready", {31'd0, pready_c}, 32'd0);
    chk("abort_c1_prdata", prdata_c, wr ? 32'd0 : ref_mem[0][addr]);
    @(posedge clk); #1;
    psel0 = 1'b0;
    @(negedge clk);
    chk("abort_c2_pready", {31'd0, pready_c}, 32'd0);
    @(posedge clk); #1;
    penable = 1'b0;
    @(negedge clk);
    chk("abort_idle_pready", {31'd0, pready_c}, 32'd0);
    chk("abort_idle_prdata", prdata_c, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[0][i] = '0;
      ref_mem[1][i] = '0;
    end
    cur     = 0;
    presetn = 1'b0;
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_prdata", ifc0.PRDATA, 32'd0);
    chk("reset_pready", {31'd0, ifc0.PREADY}, 32'd0);
    chk("reset_pslverr", {31'd0, ifc0.PSLVERR}, 32'd0);
    presetn = 1'b1;

    // Read after reset: zero data, no error, ready in the third ACCESS cycle.
    xfer(0, 1'b0, 5, 32'd0, 2);

    // Back-to-back write then read of the same word.
    xfer(0, 1'b1, 10, 32'hDEADBEEF, 2);
    xfer(0, 1'b0, 10, 32'd0, 2);
    chk("b2b_model", ref_mem[0][10], 32'hDEADBEEF);

    // Out-of-range write must error and leave word 0 untouched.
    xfer(0, 1'b1, 0, $urandom, 2);
    xfer(0, 1'b1, 64, 32'hFFFF0000, 2);
    xfer(0, 1'b0, 0, 32'd0, 2);
    xfer(0, 1'b0, 64, 32'd0, 2);

    // Aborted write keeps the old value; aborted read clears PRDATA.
    xfer(0, 1'b1, 3, 32'h0BB0_3333, 2);
    go_idle();
    abort_xfer(1'b1, 3, 32'h12345678);
    xfer(0, 1'b0, 3, 32'd0, 2);
    go_idle();
    abort_xfer(1'b0, 10, 32'd0);

    // Reset in the middle of a write clears outputs and the whole memory.
    xfer(0, 1'b1, 7, 32'hA5A5A5A5, 2);
    @(posedge clk); #1;
    pwrite  = 1'b1;
    paddr   = 8'd7;
    pwdata  = 32'h0BADF00D;
    penable = 1'b0;
    psel0   = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    presetn = 1'b0;
    @(posedge clk); #1;
    presetn = 1'b1;
    psel0   = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    chk("rst_mid_prdata", ifc0.PRDATA, 32'd0);
    chk("rst_mid_pready", {31'd0, ifc0.PREADY}, 32'd0);
    chk("rst_mid_pslverr", {31'd0, ifc0.PSLVERR}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      ref_mem[0][i] = '0;
      ref_mem[1][i] = '0;
    end
    xfer(0, 1'b0, 7, 32'd0, 2);
    chk("rst_mid_read7", ref_mem[0][7], 32'd0);

    // Random traffic including out-of-range addresses.
    for (int n = 0; n < 24; n++) begin
      xfer(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 70)), $urandom, 2);
    end
    go_idle();

    // Zero-wait-state slave: write/read pairs on words 0..7.
    for (int a = 0; a < 8; a++) begin
      xfer(1, 1'b1, a, $urandom, 0);
      xfer(1, 1'b0, a, 32'd0, 0);
    end
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
